// File: rtl/core_psum_acc.sv
// PSUM accumulation stage: streams output vectors into PSUM memory, either
// overwriting or read-modify-write accumulating with per-lane saturation.

module sram_32b_w2048 #(
  parameter int unsigned num   = 2048,
  parameter int unsigned width = 32
) (
  input  logic                     clk,
  input  logic                     cen,
  input  logic                     wen,
  input  logic [$clog2(num)-1:0]   a,
  input  logic [width-1:0]         d,
  output logic [width-1:0]         q
);

  logic [width-1:0] mem [num];

  // Active-low enables; Q updates only on a read and holds otherwise.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[a] <= d;
      else      q      <= mem[a];
    end
  end

endmodule

module core_psum_acc #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic                     acc_start,
  input  logic [addr_w-1:0]        acc_base,
  input  logic [addr_w:0]          acc_len,
  input  logic                     acc_clear,
  output logic                     acc_busy,
  output logic                     acc_done,
  output logic                     acc_sat,
  input  logic                     rd_en,
  input  logic [addr_w-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [psum_bw*col-1:0]   rd_data
);

  localparam int unsigned data_w = psum_bw * col;
  localparam int unsigned cnt_w  = addr_w + 1;
  localparam int unsigned depth  = 1 << addr_w;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [addr_w-1:0]   base_r;
  logic [cnt_w-1:0]    len_r;
  logic                clear_r;
  logic [cnt_w-1:0]    cnt;
  logic [data_w-1:0]   data_r;
  logic [addr_w-1:0]   addr_r;
  logic                wr_valid;
  logic [data_w-1:0]   rd_hold;

  logic                start_c;
  logic                accept_c;
  logic                host_rd_c;
  logic [addr_w-1:0]   acc_addr_c;
  logic [data_w-1:0]   sum_c;
  logic [col-1:0]      lane_ovf_c;

  logic                sram_cen, sram_wen;
  logic [addr_w-1:0]   sram_a;
  logic [data_w-1:0]   sram_d, sram_q;

  assign start_c    = (state == IDLE) && acc_start;
  assign host_rd_c  = ((state == IDLE) || (state == DONE)) && rd_en && !acc_start;
  assign acc_addr_c = base_r + cnt[addr_w-1:0];
  // In accumulate mode the write-back cycle owns the SRAM, so no accept then.
  assign in_ready   = (state == RUN) && (cnt < len_r) && !(!clear_r && wr_valid);
  assign accept_c   = in_valid && in_ready;
  assign rd_data    = rd_valid ? sram_q : rd_hold;

  // Lane-wise signed saturating add of stored psum and registered input.
  for (genvar g = 0; g < int'(col); g++) begin : g_lane
    logic [psum_bw-1:0] lane_a, lane_b;
    logic [psum_bw:0]   lane_s;
    assign lane_a        = sram_q[g*psum_bw +: psum_bw];
    assign lane_b        = data_r[g*psum_bw +: psum_bw];
    assign lane_s        = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
    assign lane_ovf_c[g] = lane_s[psum_bw] ^ lane_s[psum_bw-1];
    assign sum_c[g*psum_bw +: psum_bw] =
      !lane_ovf_c[g]    ? lane_s[psum_bw-1:0] :
      lane_s[psum_bw]   ? {1'b1, {(psum_bw-1){1'b0}}} :
                          {1'b0, {(psum_bw-1){1'b1}}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_c) state_nxt = (acc_len == '0) ? DONE : RUN;
      RUN:  if (wr_valid && (cnt == len_r)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single SRAM port: write-back has priority, then accumulate read, then host read.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = rd_addr;
    sram_d   = data_r;
    if (wr_valid) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_a   = addr_r;
      sram_d   = clear_r ? data_r : sum_c;
    end else if (accept_c && !clear_r) begin
      sram_cen = 1'b0;
      sram_a   = acc_addr_c;
    end else if (host_rd_c) begin
      sram_cen = 1'b0;
      sram_a   = rd_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      base_r   <= '0;
      len_r    <= '0;
      clear_r  <= 1'b0;
      cnt      <= '0;
      data_r   <= '0;
      addr_r   <= '0;
      wr_valid <= 1'b0;
      acc_busy <= 1'b0;
      acc_done <= 1'b0;
      acc_sat  <= 1'b0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
    end else begin
      state    <= state_nxt;
      acc_busy <= (state_nxt == RUN);
      acc_done <= (state_nxt == DONE);
      wr_valid <= accept_c;
      rd_valid <= host_rd_c;
      if (rd_valid) rd_hold <= sram_q;
      if (accept_c) begin
        data_r <= in_data;
        addr_r <= acc_addr_c;
        cnt    <= cnt + cnt_w'(1);
      end
      if (start_c) begin
        base_r  <= acc_base;
        len_r   <= acc_len;
        clear_r <= acc_clear;
        cnt     <= '0;
        acc_sat <= 1'b0;
      end else if (wr_valid && !clear_r && (|lane_ovf_c)) begin
        acc_sat <= 1'b1;
      end
    end
  end

  sram_32b_w2048 #(
    .num   (depth),
    .width (data_w)
  ) u_psum_mem (
    .clk (clk),
    .cen (sram_cen),
    .wen (sram_wen),
    .a   (sram_a),
    .d   (sram_d),
    .q   (sram_q)
  );

endmodule

// File: tb/tb_core_psum_acc.sv
// Directed bench for core_psum_acc: job table plus readback table, and
// hand-written sequences for start/read collision and reset mid-job.

module tb_core_psum_acc;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         acc_start;
  logic [10:0]  acc_base;
  logic [11:0]  acc_len;
  logic         acc_clear;
  logic         acc_busy;
  logic         acc_done;
  logic         acc_sat;
  logic         rd_en;
  logic [10:0]  rd_addr;
  logic         rd_valid;
  logic [127:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  core_psum_acc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .acc_start (acc_start),
    .acc_base  (acc_base),
    .acc_len   (acc_len),
    .acc_clear (acc_clear),
    .acc_busy  (acc_busy),
    .acc_done  (acc_done),
    .acc_sat   (acc_sat),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             clear;
    logic [10:0]      base;
    int               len;
    logic [3:0][15:0] vals;
    logic [15:0]      exp_pat;
    int               exp_cyc;
    logic             exp_sat;
    int               rb_lo;
    int               rb_n;
  } job_t;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] lane;
  } rb_t;

  job_t jobs [6];
  rb_t  rb   [20];

  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a job and stream its vectors; returns the in_ready pattern seen
  // from the first RUN cycle until acc_done, and the cycle count.
  task automatic run_job(input logic clear, input logic [10:0] base, input int len,
                         input logic [3:0][15:0] vals,
                         output logic [15:0] pat, output int cyc, output int nacc);
    logic acc;
    acc_start = 1'b1;
    acc_base  = base;
    acc_len   = 12'(len);
    acc_clear = clear;
    step();
    acc_start = 1'b0;
    pat  = '0;
    cyc  = 0;
    nacc = 0;
    in_valid = 1'b1;
    in_data  = rep(vals[0]);
    while (!acc_done && cyc < 40) begin
      acc = in_ready & in_valid;
      pat = {pat[14:0], in_ready};
      step();
      cyc++;
      if (acc) begin
        nacc++;
        if (nacc < len) in_data = rep(vals[nacc]);
        else            in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic host_read(input logic [10:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en   = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int          cyc, nacc, waitc;
    logic [127:0] last;

    jobs[0] = '{1'b1, 11'd0,    4, {16'h3, 16'h2, 16'h1, 16'h0},          16'h001E, 5, 1'b0, 0,  4};
    jobs[1] = '{1'b0, 11'd0,    4, {16'h3, 16'h2, 16'h1, 16'h0},          16'h00AA, 8, 1'b0, 4,  4};
    jobs[2] = '{1'b1, 11'd10,   2, {16'h0, 16'h0, 16'h8005, 16'h7FF0},    16'h0006, 3, 1'b0, 0,  0};
    jobs[3] = '{1'b0, 11'd10,   2, {16'h0, 16'h0, 16'hFFF0, 16'h0020},    16'h000A, 4, 1'b1, 8,  2};
    jobs[4] = '{1'b1, 11'd2046, 4, {16'h44, 16'h33, 16'h22, 16'h11},      16'h001E, 5, 1'b0, 10, 5};
    jobs[5] = '{1'b1, 11'd0,    0, {16'h0, 16'h0, 16'h0, 16'h5555},       16'h0000, 0, 1'b0, 15, 1};

    rb[0]  = '{11'd0,    16'h0000};
    rb[1]  = '{11'd1,    16'h0001};
    rb[2]  = '{11'd2,    16'h0002};
    rb[3]  = '{11'd3,    16'h0003};
    rb[4]  = '{11'd0,    16'h0000};
    rb[5]  = '{11'd1,    16'h0002};
    rb[6]  = '{11'd2,    16'h0004};
    rb[7]  = '{11'd3,    16'h0006};
    rb[8]  = '{11'd10,   16'h7FFF};
    rb[9]  = '{11'd11,   16'h8000};
    rb[10] = '{11'd2046, 16'h0011};
    rb[11] = '{11'd2047, 16'h0022};
    rb[12] = '{11'd0,    16'h0033};
    rb[13] = '{11'd1,    16'h0044};
    rb[14] = '{11'd2,    16'h0004};
    rb[15] = '{11'd0,    16'h0033};
    rb[16] = '{11'd0,    16'h0133};
    rb[17] = '{11'd1,    16'h0244};
    rb[18] = '{11'd2,    16'h0004};
    rb[19] = '{11'd3,    16'h0006};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; acc_start = 1'b0;
    acc_base = '0; acc_len = '0; acc_clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    step(); step();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy",     128'(acc_busy), 128'(0));
    chk("rst_done",     128'(acc_done), 128'(0));
    chk("rst_sat",      128'(acc_sat),  128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_data",  rd_data,        128'(0));
    reset = 1'b0;
    step();

    for (int j = 0; j < 6; j++) begin
      run_job(jobs[j].clear, jobs[j].base, jobs[j].len, jobs[j].vals, pat, cyc, nacc);
      chk($sformatf("job%0d_ready_pat", j), 128'(pat),      128'(jobs[j].exp_pat));
      chk($sformatf("job%0d_cycles", j),    128'(cyc),      128'(jobs[j].exp_cyc));
      chk($sformatf("job%0d_accepts", j),   128'(nacc),     128'(jobs[j].len));
      chk($sformatf("job%0d_done", j),      128'(acc_done), 128'(1));
      chk($sformatf("job%0d_busy_done", j), 128'(acc_busy), 128'(0));
      chk($sformatf("job%0d_sat", j),       128'(acc_sat),  128'(jobs[j].exp_sat));
      step();
      chk($sformatf("job%0d_done_pulse", j), 128'(acc_done), 128'(0));
      for (int r = jobs[j].rb_lo; r < jobs[j].rb_lo + jobs[j].rb_n; r++) begin
        host_read(rb[r].addr);
        chk($sformatf("rb%0d_valid", r), 128'(rd_valid), 128'(1));
        chk($sformatf("rb%0d_addr%0d", r, rb[r].addr), rd_data, rep(rb[r].lane));
      end
      if (jobs[j].rb_n > 0) begin
        last = rep(rb[jobs[j].rb_lo + jobs[j].rb_n - 1].lane);
        step();
        chk($sformatf("job%0d_rd_hold_valid", j), 128'(rd_valid), 128'(0));
        chk($sformatf("job%0d_rd_hold_data", j),  rd_data,        last);
      end
    end

    // acc_start and rd_en together in IDLE: start wins, read dropped.
    acc_start = 1'b1; acc_len = '0; acc_base = '0; acc_clear = 1'b1;
    rd_en = 1'b1; rd_addr = 11'd1;
    step();
    acc_start = 1'b0; rd_en = 1'b0;
    chk("collide_rd_valid", 128'(rd_valid), 128'(0));
    chk("collide_done",     128'(acc_done), 128'(1));
    step();

    // Reset mid-job: accumulate two vectors into a len=4 job, then reset.
    acc_start = 1'b1; acc_base = '0; acc_len = 12'd4; acc_clear = 1'b0;
    step();
    acc_start = 1'b0;
    chk("mid_busy", 128'(acc_busy), 128'(1));
    in_valid = 1'b1; in_data = rep(16'h0100);
    nacc = 0; waitc = 0;
    while (nacc < 2 && waitc < 20) begin
      if (in_ready) begin
        step();
        nacc++;
        in_data = rep(16'h0200);
      end else begin
        step();
      end
      waitc++;
    end
    in_valid = 1'b0;
    chk("mid_accepts", 128'(nacc), 128'(2));
    step();
    rd_en = 1'b1; rd_addr = 11'd3;
    acc_start = 1'b1; acc_len = '0;
    step();
    rd_en = 1'b0; acc_start = 1'b0;
    chk("mid_rd_dropped",    128'(rd_valid), 128'(0));
    chk("mid_start_ignored", 128'(acc_busy), 128'(1));
    chk("mid_no_done",       128'(acc_done), 128'(0));
    chk("mid_ready_open",    128'(in_ready), 128'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",  128'(acc_busy), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(0));
    step();
    reset = 1'b0;
    step();
    for (int r = 16; r < 20; r++) begin
      host_read(rb[r].addr);
      chk($sformatf("rb%0d_valid", r), 128'(rd_valid), 128'(1));
      chk($sformatf("rb%0d_addr%0d", r, rb[r].addr), rd_data, rep(rb[r].lane));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
